// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: {cout, sum} = a + b + cin, DIGIT bits per clock, LSD first.
// Optional signed-overflow output enabled by defining DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              valid_q, valid_d;
  logic [DIGIT:0]    dig;
  logic [WIDTH-1:0]  acc_next;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
  logic              msb_cin;
`endif

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

  always_comb begin
    dig      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    // New digit enters at the top; after NDIG shifts the LSD sits at bit 0.
    acc_next = (acc_q >> DIGIT) | (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    msb_cin  = dig[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    ovf_d    = ovf_q;
`endif
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig[DIGIT];
        acc_d   = acc_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          sum_d   = acc_next;
          cout_d  = dig[DIGIT];
          valid_d = 1'b1;
          state_d = HOLD;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
          ovf_d   = msb_cin ^ dig[DIGIT];
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed-vector bench for digit_serial_adder: four instances (DIGIT=4,1,16,8) at WIDTH=16.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vin[4], inr[4], vout[4], ordy[4], cin_s[4], cout_s[4];
  logic [15:0] a_s[4], b_s[4], sum_s[4];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic        ovf_s[4];
`endif

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int DG = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 16 : 8;
    digit_serial_adder #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(vin[k]), .in_ready(inr[k]),
      .a(a_s[k]), .b(b_s[k]), .cin(cin_s[k]),
      .out_valid(vout[k]), .out_ready(ordy[k]),
      .sum(sum_s[k]), .cout(cout_s[k])
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      , .ovf(ovf_s[k])
`endif
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_lat[4] = '{4, 16, 1, 2};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  vec_t tbl[9];

  // Starts at (or just after) a falling edge with DUT k idle; returns at a falling edge, idle again.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] s, output logic co, output logic ov, output int lat);
    check($sformatf("k%0d in_ready before accept", k), inr[k], 1);
    vin[k] = 1'b1; a_s[k] = a; b_s[k] = b; cin_s[k] = c;
    @(posedge clk);
    @(negedge clk);
    vin[k] = 1'b0;
    a_s[k] = 16'($urandom); b_s[k] = 16'($urandom); cin_s[k] = 1'($urandom);
    lat = 0;
    while (!vout[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("k%0d out_valid rises", k), vout[k], 1);
    s  = sum_s[k];
    co = cout_s[k];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ov = ovf_s[k];
`else
    ov = 1'b0;
`endif
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    check($sformatf("k%0d out_valid drops after handshake", k), vout[k], 0);
    check($sformatf("k%0d sum retained in idle", k), sum_s[k], s);
  endtask

  initial begin
    logic [15:0] s;
    logic        co, ov;
    int          lat, n;
    logic [16:0] ref_v;
    logic [15:0] ra, rb;
    logic        rc;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    for (int k = 0; k < 4; k++) begin
      vin[k] = 1'b0; ordy[k] = 1'b0; cin_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0;
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("k%0d reset out_valid", k), vout[k], 0);
      check($sformatf("k%0d reset sum", k), sum_s[k], 0);
      check($sformatf("k%0d reset cout", k), cout_s[k], 0);
      check($sformatf("k%0d reset in_ready", k), inr[k], 0);
    end
    rst_n = 1'b1;
    #1;
    check("in_ready after reset release", inr[0], 1);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) begin
        run_op(k, tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov, lat);
        check($sformatf("k%0d v%0d sum", k, i), s, tbl[i].s);
        check($sformatf("k%0d v%0d cout", k, i), co, tbl[i].co);
        check($sformatf("k%0d v%0d latency", k, i), lat, exp_lat[k]);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        check($sformatf("k%0d v%0d ovf", k, i), ov, tbl[i].ov);
`endif
      end
      for (int i = 0; i < 8; i++) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        ref_v = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
        run_op(k, ra, rb, rc, s, co, ov, lat);
        check($sformatf("k%0d rnd%0d result", k, i), {co, s}, ref_v);
        check($sformatf("k%0d rnd%0d latency", k, i), lat, exp_lat[k]);
      end
    end

    // Reset in the middle of RUN aborts and clears everything, sum included.
    vin[0] = 1'b1; a_s[0] = 16'h1234; b_s[0] = 16'h4321; cin_s[0] = 1'b0;
    @(negedge clk);
    vin[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midrst c%0d out_valid", c), vout[0], 0);
      check($sformatf("midrst c%0d sum", c), sum_s[0], 0);
      check($sformatf("midrst c%0d cout", c), cout_s[0], 0);
      check($sformatf("midrst c%0d in_ready", c), inr[0], 0);
    end
    rst_n = 1'b1;
    #1;
    check("midrst in_ready after release", inr[0], 1);
    run_op(0, 16'h1234, 16'h4321, 1'b0, s, co, ov, lat);
    check("post-reset sum", s, 16'h5555);
    check("post-reset latency", lat, 4);

    // Backpressure in HOLD with new operands waiting.
    vin[0] = 1'b1; a_s[0] = 16'h1111; b_s[0] = 16'h2222; cin_s[0] = 1'b0;
    @(negedge clk);
    vin[0] = 1'b0;
    n = 0;
    while (!vout[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp first result valid", vout[0], 1);
    vin[0] = 1'b1; a_s[0] = 16'h0101; b_s[0] = 16'h0202; cin_s[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp c%0d out_valid", c), vout[0], 1);
      check($sformatf("bp c%0d in_ready", c), inr[0], 0);
      check($sformatf("bp c%0d sum held", c), sum_s[0], 16'h3333);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    check("bp out_valid after handshake", vout[0], 0);
    check("bp in_ready back in idle", inr[0], 1);
    @(negedge clk);
    vin[0] = 1'b0; a_s[0] = 16'hFFFF; b_s[0] = 16'hFFFF;
    check("bp new operands accepted", inr[0], 0);
    n = 0;
    while (!vout[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp second result valid", vout[0], 1);
    check("bp second sum", sum_s[0], 16'h0303);
    check("bp second cout", cout_s[0], 0);
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
